// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic int mul_steps(input int len, input int step);
        return len / step;
    endfunction

    // Operand width must be even and at least 4; STEP must be 1, 2 or 4 and divide LEN.
    function automatic bit mul_cfg_legal(input int len, input int step);
        return (len >= 4) && (len % 2 == 0) &&
               (step == 1 || step == 2 || step == 4) && (len % step == 0);
    endfunction

endpackage

// File: rtl/mul_step.sv
// Combinational datapath for one iteration: adds |A| * STEP-bit slice of B,
// shifted to the weight of the current step index, into the accumulator.
module mul_step
    import mul_pkg::*;
#(
    parameter int LEN  = 32,
    parameter int STEP = 1,
    parameter int CW   = 6
) (
    input  logic [2*LEN-1:0] acc_i,
    input  logic [LEN-1:0]   a_i,
    input  logic [STEP-1:0]  b_slice_i,
    input  logic [CW-1:0]    idx_i,
    output logic [2*LEN-1:0] acc_o
);

    logic [2*LEN-1:0] partial;
    logic [31:0]      shamt;

    always_comb begin
        partial = {{LEN{1'b0}}, a_i} * {{(2*LEN-STEP){1'b0}}, b_slice_i};
        shamt   = 32'(idx_i) * 32'(STEP);
        acc_o   = acc_i + (partial << shamt);
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, STEP bits per cycle, signed/unsigned per operation.
// Define MUL_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are zero.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int LEN  = 32,
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN-1:0]   multiplicand,
    input  logic [LEN-1:0]   multiplier,
    input  logic             is_signed,
    input  logic             start,
    output logic             busy,
    output logic             finish,
    output logic [2*LEN-1:0] product
);

    localparam int N  = mul_steps(LEN, STEP);
    localparam int CW = $clog2(N + 1);

    if (!mul_cfg_legal(LEN, STEP)) begin : g_cfg_err
        $error("seq_multiplier: illegal LEN/STEP combination");
    end

    mul_state_t       state_q, state_d;
    logic [LEN-1:0]   a_q, a_d;
    logic [LEN-1:0]   b_rem_q, b_rem_d;
    logic [2*LEN-1:0] acc_q, acc_d;
    logic [2*LEN-1:0] product_q, product_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             busy_q, busy_d;
    logic             finish_q, finish_d;

    logic [2*LEN-1:0] acc_step;
    logic [LEN-1:0]   b_rem_shifted;
    logic             accept;
    logic             last_step;

    mul_step #(
        .LEN  (LEN),
        .STEP (STEP),
        .CW   (CW)
    ) u_step (
        .acc_i     (acc_q),
        .a_i       (a_q),
        .b_slice_i (b_rem_q[STEP-1:0]),
        .idx_i     (cnt_q),
        .acc_o     (acc_step)
    );

    always_comb begin
        accept        = start && (state_q == IDLE || state_q == DONE);
        b_rem_shifted = b_rem_q >> STEP;
`ifdef MUL_EARLY_EXIT_EN
        last_step     = (cnt_q == CW'(N - 1)) || (b_rem_shifted == '0);
`else
        last_step     = (cnt_q == CW'(N - 1));
`endif

        state_d   = state_q;
        a_d       = a_q;
        b_rem_d   = b_rem_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    // Signed mode works on magnitudes; the most negative value maps to 2^(LEN-1).
                    a_d     = (is_signed && multiplicand[LEN-1]) ? -multiplicand : multiplicand;
                    b_rem_d = (is_signed && multiplier[LEN-1])   ? -multiplier   : multiplier;
                    sign_d  = is_signed && (multiplicand[LEN-1] ^ multiplier[LEN-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                acc_d   = acc_step;
                b_rem_d = b_rem_shifted;
                cnt_d   = cnt_q + CW'(1);
                if (last_step) begin
                    state_d   = DONE;
                    product_d = sign_q ? -acc_step : acc_step;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d == BUSY);
        finish_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_rem_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_rem_q   <= b_rem_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
        end
    end

    assign busy    = busy_q;
    assign finish  = finish_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: one STEP=1 and one STEP=4 instance, LEN=32.
// Latency expectations follow MUL_EARLY_EXIT_EN when it is defined.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst1, rst4;
    logic [31:0] a1, b1, a4, b4;
    logic        sg1, sg4, start1, start4;
    logic        busy1, busy4, finish1, finish4;
    logic [63:0] product1, product4;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.LEN(32), .STEP(1)) dut1 (
        .clk(clk), .rst(rst1), .multiplicand(a1), .multiplier(b1),
        .is_signed(sg1), .start(start1), .busy(busy1), .finish(finish1),
        .product(product1)
    );

    seq_multiplier #(.LEN(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst4), .multiplicand(a4), .multiplier(b4),
        .is_signed(sg4), .start(start4), .busy(busy4), .finish(finish4),
        .product(product4)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveInputs(input int sel, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic sg);
        if (sel == 1) begin
            start1 = s; a1 = a; b1 = b; sg1 = sg;
        end else begin
            start4 = s; a4 = a; b4 = b; sg4 = sg;
        end
    endtask

    function automatic logic getBusy(input int sel);
        return (sel == 1) ? busy1 : busy4;
    endfunction

    function automatic logic getFinish(input int sel);
        return (sel == 1) ? finish1 : finish4;
    endfunction

    function automatic logic [63:0] getProduct(input int sel);
        return (sel == 1) ? product1 : product4;
    endfunction

    // Cycles from accept to finish for this multiplier operand and STEP.
    function automatic int expLatency(input logic [31:0] b, input logic sg, input int step);
        logic [31:0] mag;
        int msb;
        mag = (sg && b[31]) ? -b : b;
        msb = -1;
        for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
`ifdef MUL_EARLY_EXIT_EN
        if (msb < 0) return 1;
        return (msb + step) / step;
`else
        return (msb >= -1) ? 32 / step : 0;
`endif
    endfunction

    // Full operation with a single-cycle start pulse, checking busy, finish timing and product.
    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                                 input logic sg, input logic [63:0] expProd, input string tag);
        int  lat, cyc, busyCyc;
        bit  seen;
        lat = expLatency(b, sg, (sel == 1) ? 1 : 4);
        @(negedge clk);
        driveInputs(sel, 1'b1, a, b, sg);
        @(posedge clk); #1;
        driveInputs(sel, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput({tag, " busy after accept"}, 64'(getBusy(sel)), 64'd1);
        cyc = 0; busyCyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            if (getBusy(sel)) busyCyc++;
            @(posedge clk); #1;
            cyc++;
            if (getFinish(sel)) seen = 1;
        end
        checkOutput({tag, " latency"}, 64'(cyc), 64'(lat));
        checkOutput({tag, " busy cycles"}, 64'(busyCyc), 64'(lat));
        checkOutput({tag, " product"}, getProduct(sel), expProd);
        checkOutput({tag, " busy at finish"}, 64'(getBusy(sel)), 64'd0);
        @(posedge clk); #1;
        checkOutput({tag, " finish one cycle"}, 64'(getFinish(sel)), 64'd0);
        checkOutput({tag, " idle busy"}, 64'(getBusy(sel)), 64'd0);
        checkOutput({tag, " product held"}, getProduct(sel), expProd);
    endtask

    initial begin
        int  cyc, lat, finCount, abortCyc;
        bit  seen;

        rst1 = 1'b1; rst4 = 1'b1;
        driveInputs(1, 1'b0, 32'h0, 32'h0, 1'b0);
        driveInputs(4, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy1", 64'(busy1), 64'd0);
        checkOutput("reset finish1", 64'(finish1), 64'd0);
        checkOutput("reset product1", product1, 64'd0);
        checkOutput("reset busy4", 64'(busy4), 64'd0);
        checkOutput("reset product4", product4, 64'd0);
        @(negedge clk);
        rst1 = 1'b0; rst4 = 1'b0;

        $display("[TB] STEP=1 directed vectors");
        applyStimulus(1, 32'd20, 32'd40, 1'b0, 64'd800, "20x40");
        applyStimulus(1, 32'hFFFF_FFFD, 32'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "-3x7 signed");
        applyStimulus(1, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "minneg sq");
        applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "ones unsigned");
        applyStimulus(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, "ones signed");
        applyStimulus(1, 32'd7, 32'd0, 1'b0, 64'd0, "7x0");
        applyStimulus(1, 32'd20, 32'd40, 1'b0, 64'd800, "20x40 again");

        $display("[TB] abort mid-operation");
        lat = expLatency(32'd40, 1'b0, 1);
        abortCyc = (lat > 12) ? 10 : 3;
        @(negedge clk);
        driveInputs(1, 1'b1, 32'd20, 32'd40, 1'b0);
        @(posedge clk); #1;
        driveInputs(1, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (abortCyc - 1) begin
            @(posedge clk); #1;
        end
        checkOutput("abort busy before rst", 64'(busy1), 64'd1);
        @(negedge clk);
        rst1 = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort busy", 64'(busy1), 64'd0);
        checkOutput("abort finish", 64'(finish1), 64'd0);
        checkOutput("abort product", product1, 64'd0);
        @(negedge clk);
        rst1 = 1'b0;
        finCount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (finish1) finCount++;
        end
        checkOutput("abort no finish", 64'(finCount), 64'd0);
        applyStimulus(1, 32'd5, 32'd5, 1'b0, 64'd25, "5x5 after abort");

        $display("[TB] STEP=4 start ignored while busy");
        lat = expLatency(32'd6789, 1'b0, 4);
        @(negedge clk);
        driveInputs(4, 1'b1, 32'd12345, 32'd6789, 1'b0);
        @(posedge clk); #1;
        driveInputs(4, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            if (cyc == 2) driveInputs(4, 1'b1, 32'd1, 32'd1, 1'b0);
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) begin
                driveInputs(4, 1'b0, 32'h0, 32'h0, 1'b0);
                checkOutput("step4 busy after stray start", 64'(busy4), 64'd1);
            end
            if (finish4) seen = 1;
        end
        checkOutput("step4 latency", 64'(cyc), 64'(lat));
        checkOutput("step4 product", product4, 64'd83810205);
        @(posedge clk); #1;
        checkOutput("step4 finish drop", 64'(finish4), 64'd0);
        checkOutput("step4 product held", product4, 64'd83810205);

        $display("[TB] STEP=4 back-to-back with start held");
        lat = expLatency(32'd4, 1'b0, 4);
        @(negedge clk);
        driveInputs(4, 1'b1, 32'd3, 32'd4, 1'b0);
        @(posedge clk); #1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (finish4) seen = 1;
        end
        checkOutput("b2b first latency", 64'(cyc), 64'(lat));
        checkOutput("b2b first product", product4, 64'd12);
        driveInputs(4, 1'b1, 32'd6, 32'd7, 1'b0);
        lat = expLatency(32'd7, 1'b0, 4);
        @(posedge clk); #1;
        driveInputs(4, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("b2b restart busy", 64'(busy4), 64'd1);
        checkOutput("b2b restart finish", 64'(finish4), 64'd0);
        checkOutput("b2b product stable", product4, 64'd12);
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (finish4) seen = 1;
        end
        checkOutput("b2b second latency", 64'(cyc), 64'(lat));
        checkOutput("b2b second product", product4, 64'd42);
        @(posedge clk); #1;
        checkOutput("b2b idle", 64'(busy4 | finish4), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier, the parametrised successor of the fixed unsigned `Multiplier`. Width is generic, the retire rate is configurable at STEP multiplier bits per cycle, and signed or unsigned mode is selected per operation. It uses the same start/finish handshake, so existing `Multiplier` testbenches and `Judge`-style checkers can drive it unchanged.

## Interface
- LEN, 32, operand width; even, ≥4
- STEP, 1, multiplier bits retired per cycle; LEN % STEP == 0; legal values 1, 2, 4
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- multiplicand  in  LEN  operand A, sampled only at accept edge
- multiplier  in  LEN  operand B, sampled only at accept edge
- is_signed  in  1  1 = two's-complement operands/product; sampled at accept edge
- start  in  1  request; level-sampled
- busy  out  1  high while computing
- finish  out  1  one-cycle done pulse
- product  out  2*LEN  result, held until next accept

## Operation
- States: IDLE, BUSY, DONE.
- Accept edge: rising edge with start=1 and state IDLE or DONE. Operands and mode are latched; state goes to BUSY.
- start while BUSY is ignored. start held high restarts on the DONE cycle, giving back-to-back throughput.
- Signed mode:
  - Latch magnitudes |A| and |B| as LEN-bit unsigned; -2^(LEN-1) maps to 2^(LEN-1).
  - Latch sign = A[msb] ^ B[msb].
  - Negate the 2*LEN-bit result on entry to DONE when sign=1.
- Unsigned mode: operands are used as-is.
- Each BUSY edge does one step:
  - acc += |A| * B_rem[STEP-1:0] << (k*STEP), where k is the step index.
  - B_rem >>= STEP.
  - The accumulator is 2*LEN bits wide and cannot overflow.
- BUSY → DONE after N = LEN/STEP steps. DONE → IDLE on the next edge unless a new accept occurs.
- busy=1 iff state==BUSY; finish=1 iff state==DONE.
- product updates only on entry to DONE and is stable otherwise.
- Reset values: state IDLE, busy=0, finish=0, product=0, internal accumulator and counters 0.
- Reset mid-operation aborts the operation: no finish pulse, product forced to 0.
- rst has priority over start in the same cycle.

## Timing
- Accept edge E0: busy is high from E0 until edge E0+N, i.e. exactly N cycles.
- finish is high for exactly one cycle, between edges E0+N and E0+N+1. product is valid in that same cycle.
- Latency from accept edge to finish: N cycles. Examples: 32 for LEN=32/STEP=1; 8 for STEP=4.
- Back-to-back with start held: accept in the DONE cycle, so the period is N+1 cycles.
- Inputs are don't-care outside the accept edge.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - BUSY ends once B_rem == 0 after a step, with a minimum of 1 step.
  - Latency = max(1, ceil((msb_index(|B|)+1)/STEP)); |B|=0 gives 1.
  - Negation and the finish/product rules are unchanged.
- MUL_EARLY_EXIT_EN undefined: latency is fixed at N for all operands. The early-exit comparator is not synthesised.

## Structure
- Package `mul_pkg`:
  - `mul_state_t` enum {IDLE, BUSY, DONE}.
  - Function `mul_steps(LEN, STEP)` returning N.
  - Elaboration-time checks on LEN/STEP legality.
- Sub-module `mul_step`:
  - Combinational.
  - Inputs: acc, |A|, a STEP-bit slice of B, step index.
  - Output: next acc.
  - Instantiated once.
- Counter width: $clog2(N+1).

## Test plan
- LEN=32, STEP=1, unsigned, 20×40 → product=800 (0x320). finish exactly 32 cycles after accept; busy high for 32 cycles.
- Signed pair, all LEN=32:
  - -3×7 (0xFFFFFFFD, 0x7) → 0xFFFFFFFF_FFFFFFEB.
  - 0x80000000×0x80000000 → 0x40000000_00000000.
- Signed vs unsigned, 0xFFFFFFFF×0xFFFFFFFF:
  - unsigned → 0xFFFFFFFE_00000001.
  - signed → 1.
- STEP=4, 12345×6789 unsigned → 83810205. finish after 8 cycles. start pulsed again at BUSY cycle 3 → ignored, result unchanged.
- Abort and restart:
  - Start 20×40, assert rst on BUSY cycle 10 → no finish, product=0, busy=0 next cycle.
  - Then start 5×5 → 25 after 32 cycles.
- MUL_EARLY_EXIT_EN, STEP=1:
  - 20×40 → 800 with finish 6 cycles after accept.
  - 7×0 → 0 after 1 cycle.
  - Same stimulus without the macro → 32 cycles.
